// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/rw/ready memory bus between instruction fetch (port 0)
// and load/store (port 1). Define MEM_TIMEOUT_EN to abort stalled accesses after TIMEOUT BUSY cycles.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_valid,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  logic          last_q;
  logic          gnt0_q, gnt1_q, done0_q, done1_q;
  logic [DW-1:0] rdata_q;
  logic          mem_valid_q, mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          win1_d;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign win1_d = req1 & (~req0 | ~last_q);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q;
  logic          err0_q, err1_q;
  assign err0 = err0_q;
  assign err1 = err1_q;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            mem_valid_q <= 1'b1;
            mem_rw_q    <= win1_d ? rw1 : rw0;
            mem_addr_q  <= win1_d ? addr1 : addr0;
            mem_wdata_q <= win1_d ? wdata1 : wdata0;
            gnt0_q      <= ~win1_d;
            gnt1_q      <= win1_d;
            last_q      <= win1_d;
            state_q     <= BUSY;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        BUSY: begin
          // last_q names the current owner for the whole transaction.
          if (mem_ready) begin
            if (mem_rw_q) rdata_q <= mem_rdata;
            mem_valid_q <= 1'b0;
            done0_q     <= ~last_q;
            done1_q     <= last_q;
            state_q     <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            mem_valid_q <= 1'b0;
            done0_q     <= ~last_q;
            done1_q     <= last_q;
            err0_q      <= ~last_q;
            err1_q      <= last_q;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
